// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: frequency-sweep sequencer that drives a DDS core.
// It steps the tuning word f_ctrl from a start value to an inclusive stop
// value, holding each word for a programmable dwell. Single, sawtooth-repeat
// and triangle sweeps are supported.
//
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   start, abort    sweep request / immediate stop (abort wins)
//   cfg_*           sweep configuration, latched only when a start is accepted
//   f_ctrl, p_ctrl  registered tuning word and phase offset to the DDS
//   busy            sweep in progress
//   step_pulse      1-cycle pulse on every f_ctrl load (including reloads)
//   done            1-cycle pulse when a single sweep completes
//   cfg_err         1-cycle pulse when a start is rejected
module dds_sweep_ctrl #(
    parameter int unsigned F_WORD_N = 32,
    parameter int unsigned P_WORD_M = 12,
    parameter int unsigned DWELL_W  = 16,
    localparam int unsigned FW      = F_WORD_N - P_WORD_M
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [FW-1:0]       cfg_f_start,
    input  logic [FW-1:0]       cfg_f_stop,
    input  logic [FW-1:0]       cfg_f_step,
    input  logic [DWELL_W-1:0]  cfg_dwell,
    input  logic [P_WORD_M-1:0] cfg_phase,
    input  logic [1:0]          cfg_mode,
    output logic [FW-1:0]       f_ctrl,
    output logic [P_WORD_M-1:0] p_ctrl,
    output logic                busy,
    output logic                step_pulse,
    output logic                done,
    output logic                cfg_err
);

    localparam logic [1:0] MODE_REPEAT   = 2'd1;
    localparam logic [1:0] MODE_TRIANGLE = 2'd2;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_t;

    state_t               state_q;
    logic                 dir_q;
    logic [FW-1:0]        f_q;
    logic [P_WORD_M-1:0]  p_q;
    logic [DWELL_W-1:0]   cnt_q;
    logic                 busy_q;
    logic                 step_pulse_q;
    logic                 done_q;
    logic                 cfg_err_q;

    // Configuration captured when a sweep is accepted
    logic [FW-1:0]        start_lat_q;
    logic [FW-1:0]        stop_lat_q;
    logic [FW-1:0]        step_lat_q;
    logic [DWELL_W-1:0]   dwell_lat_q;
    logic [1:0]           mode_lat_q;

    // Next-word candidates, computed one bit wider to expose carry/borrow
    logic [FW:0]          up_sum_c;
    logic [FW:0]          dn_diff_c;
    logic                 up_ok_c;
    logic                 dn_ok_c;
    logic [DWELL_W-1:0]   dwell_last_c;
    logic                 dwell_hit_c;
    logic                 cfg_bad_c;

    always_comb begin
        up_sum_c     = {1'b0, f_q} + {1'b0, step_lat_q};
        dn_diff_c    = {1'b0, f_q} - {1'b0, step_lat_q};
        up_ok_c      = !up_sum_c[FW] && (up_sum_c[FW-1:0] <= stop_lat_q);
        dn_ok_c      = !dn_diff_c[FW] && (dn_diff_c[FW-1:0] >= start_lat_q);
        // A dwell of 0 behaves as a dwell of 1
        dwell_last_c = (dwell_lat_q == '0) ? '0 : dwell_lat_q - DWELL_W'(1);
        dwell_hit_c  = (cnt_q == dwell_last_c);
        cfg_bad_c    = (cfg_f_step == '0) || (cfg_f_start > cfg_f_stop);
    end

    // Sweep sequencer: state, word and pulse registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            dir_q        <= 1'b0;
            f_q          <= '0;
            p_q          <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            step_pulse_q <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            start_lat_q  <= '0;
            stop_lat_q   <= '0;
            step_lat_q   <= '0;
            dwell_lat_q  <= '0;
            mode_lat_q   <= '0;
        end else begin
            step_pulse_q <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;

            if (abort) begin
                // Freeze the DDS; phase offset is left as is
                state_q <= S_IDLE;
                f_q     <= '0;
                busy_q  <= 1'b0;
                cnt_q   <= '0;
                dir_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            if (cfg_bad_c) begin
                                cfg_err_q <= 1'b1;
                            end else begin
                                start_lat_q  <= cfg_f_start;
                                stop_lat_q   <= cfg_f_stop;
                                step_lat_q   <= cfg_f_step;
                                dwell_lat_q  <= cfg_dwell;
                                mode_lat_q   <= cfg_mode;
                                f_q          <= cfg_f_start;
                                p_q          <= cfg_phase;
                                dir_q        <= 1'b0;
                                cnt_q        <= '0;
                                busy_q       <= 1'b1;
                                step_pulse_q <= 1'b1;
                                state_q      <= S_SWEEP;
                            end
                        end
                    end

                    S_SWEEP: begin
                        if (!dwell_hit_c) begin
                            cnt_q <= cnt_q + DWELL_W'(1);
                        end else begin
                            cnt_q <= '0;
                            if (!dir_q) begin
                                if (up_ok_c) begin
                                    f_q          <= up_sum_c[FW-1:0];
                                    step_pulse_q <= 1'b1;
                                end else begin
                                    case (mode_lat_q)
                                        MODE_REPEAT: begin
                                            f_q          <= start_lat_q;
                                            step_pulse_q <= 1'b1;
                                        end
                                        MODE_TRIANGLE: begin
                                            // Turn around; reload f if the range
                                            // is too narrow for a step down
                                            dir_q        <= 1'b1;
                                            f_q          <= dn_ok_c ? dn_diff_c[FW-1:0] : f_q;
                                            step_pulse_q <= 1'b1;
                                        end
                                        default: begin
                                            state_q <= S_IDLE;
                                            busy_q  <= 1'b0;
                                            done_q  <= 1'b1;
                                        end
                                    endcase
                                end
                            end else begin
                                if (dn_ok_c) begin
                                    f_q <= dn_diff_c[FW-1:0];
                                end else begin
                                    dir_q <= 1'b0;
                                    f_q   <= up_ok_c ? up_sum_c[FW-1:0] : f_q;
                                end
                                step_pulse_q <= 1'b1;
                            end
                        end
                    end

                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign f_ctrl     = f_q;
    assign p_ctrl     = p_q;
    assign busy       = busy_q;
    assign step_pulse = step_pulse_q;
    assign done       = done_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Testbench for dds_sweep_ctrl: a table of sweep configurations with their
// expected word sequences feeds a per-cycle scoreboard of expected outputs;
// hand-written sequences cover abort/start priority and reset mid-sweep.
module tb_dds_sweep_ctrl;

    localparam int unsigned FNW = 32;
    localparam int unsigned PMW = 12;
    localparam int unsigned DW  = 16;
    localparam int unsigned FW  = FNW - PMW;
    localparam int unsigned NV  = 10;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic           abort;
    logic [FW-1:0]  cfg_f_start;
    logic [FW-1:0]  cfg_f_stop;
    logic [FW-1:0]  cfg_f_step;
    logic [DW-1:0]  cfg_dwell;
    logic [PMW-1:0] cfg_phase;
    logic [1:0]     cfg_mode;
    logic [FW-1:0]  f_ctrl;
    logic [PMW-1:0] p_ctrl;
    logic           busy;
    logic           step_pulse;
    logic           done;
    logic           cfg_err;

    dds_sweep_ctrl #(
        .F_WORD_N (FNW),
        .P_WORD_M (PMW),
        .DWELL_W  (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .cfg_f_start (cfg_f_start),
        .cfg_f_stop  (cfg_f_stop),
        .cfg_f_step  (cfg_f_step),
        .cfg_dwell   (cfg_dwell),
        .cfg_phase   (cfg_phase),
        .cfg_mode    (cfg_mode),
        .f_ctrl      (f_ctrl),
        .p_ctrl      (p_ctrl),
        .busy        (busy),
        .step_pulse  (step_pulse),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [FW-1:0]  f;
        logic [PMW-1:0] p;
        logic           busy;
        logic           sp;
        logic           done;
        logic           err;
    } obs_t;

    typedef struct packed {
        logic [1:0]     mode;
        logic [FW-1:0]  fs;
        logic [FW-1:0]  fe;
        logic [FW-1:0]  st;
        logic [DW-1:0]  dwell;
        logic [PMW-1:0] phase;
        bit             err;
        bit             fin_done;
        int             ncyc;
    } vec_t;

    obs_t           sbq[$];
    vec_t           vecs[NV];
    int unsigned    words[NV][12];
    int             total = 0;
    int             bad   = 0;
    string          tag;
    logic [FW-1:0]  cur_f;
    logic [PMW-1:0] cur_p;

    function automatic vec_t mkv(input int m, input int fs, input int fe, input int st,
                                 input int dw, input int ph, input bit e, input bit fd,
                                 input int n);
        vec_t v;
        v.mode     = 2'(m);
        v.fs       = FW'(fs);
        v.fe       = FW'(fe);
        v.st       = FW'(st);
        v.dwell    = DW'(dw);
        v.phase    = PMW'(ph);
        v.err      = e;
        v.fin_done = fd;
        v.ncyc     = n;
        return v;
    endfunction

    task automatic push(input logic [FW-1:0] f, input logic [PMW-1:0] p, input logic b,
                        input logic sp, input logic d, input logic e);
        obs_t o;
        o.f = f; o.p = p; o.busy = b; o.sp = sp; o.done = d; o.err = e;
        sbq.push_back(o);
    endtask

    // Advance one clock and compare DUT outputs against the scoreboard head
    task automatic step();
        obs_t got;
        obs_t exp_o;
        @(posedge clk);
        #1;
        got = {f_ctrl, p_ctrl, busy, step_pulse, done, cfg_err};
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty, got f=%h", tag, got.f);
        end else begin
            exp_o = sbq.pop_front();
            if (got !== exp_o) begin
                bad++;
                $display("FAIL %s @%0t: got f=%h p=%h busy=%b sp=%b done=%b err=%b, need f=%h p=%h busy=%b sp=%b done=%b err=%b",
                         tag, $time, got.f, got.p, got.busy, got.sp, got.done, got.err,
                         exp_o.f, exp_o.p, exp_o.busy, exp_o.sp, exp_o.done, exp_o.err);
            end
        end
    endtask

    task automatic set_cfg(input vec_t v);
        cfg_f_start = v.fs;
        cfg_f_stop  = v.fe;
        cfg_f_step  = v.st;
        cfg_dwell   = v.dwell;
        cfg_phase   = v.phase;
        cfg_mode    = v.mode;
    endtask

    // Configuration that would be valid but must be ignored outside an accepted start
    task automatic scramble_cfg();
        cfg_f_start = FW'(7);
        cfg_f_stop  = '1;
        cfg_f_step  = FW'(1);
        cfg_dwell   = DW'(5);
        cfg_phase   = '1;
        cfg_mode    = 2'd1;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   d;
        int   last;
        v = vecs[i];
        $sformat(tag, "vec%0d", i);
        set_cfg(v);
        start = 1'b1;
        if (v.err) begin
            push(cur_f, cur_p, 1'b0, 1'b0, 1'b0, 1'b1);
            step();
            start = 1'b0;
            push(cur_f, cur_p, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
            return;
        end
        d = (v.dwell == '0) ? 1 : int'(v.dwell);
        for (int k = 0; k < v.ncyc; k++) begin
            push(FW'(words[i][k / d]), v.phase, 1'b1, (k % d) == 0, 1'b0, 1'b0);
            step();
            if (k == 0) scramble_cfg();
            // A start during the sweep must have no effect
            start = (k == 1 && v.ncyc > 3) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        cur_p = v.phase;
        if (v.fin_done) begin
            last  = (v.ncyc - 1) / d;
            cur_f = FW'(words[i][last]);
            push(cur_f, cur_p, 1'b0, 1'b0, 1'b1, 1'b0);
            step();
            push(cur_f, cur_p, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end else begin
            abort = 1'b1;
            cur_f = '0;
            push(cur_f, cur_p, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
            abort = 1'b0;
            push(cur_f, cur_p, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cfg_f_start = '0;
        cfg_f_stop  = '0;
        cfg_f_step  = '0;
        cfg_dwell   = '0;
        cfg_phase   = '0;
        cfg_mode    = '0;
        cur_f = '0;
        cur_p = '0;

        vecs[0] = mkv(0, 100, 260, 50, 3, 'h123, 1'b0, 1'b1, 12);
        vecs[1] = mkv(1, 100, 260, 50, 1, 'h010, 1'b0, 1'b0, 10);
        vecs[2] = mkv(2, 100, 260, 50, 1, 'h020, 1'b0, 1'b0, 12);
        vecs[3] = mkv(0, 'hFFFF0, 'hFFFFF, 'h20, 2, 'h7FF, 1'b0, 1'b1, 2);
        vecs[4] = mkv(0, 100, 260, 0, 1, 'h555, 1'b1, 1'b0, 0);
        vecs[5] = mkv(0, 300, 200, 50, 1, 'h555, 1'b1, 1'b0, 0);
        vecs[6] = mkv(3, 100, 260, 50, 0, 'h321, 1'b0, 1'b1, 4);
        vecs[7] = mkv(0, 100, 260, 50, 3, 'h0F0, 1'b0, 1'b0, 7);
        vecs[8] = mkv(2, 100, 260, 50, 2, 'hABC, 1'b0, 1'b0, 10);
        vecs[9] = mkv(0, 500, 500, 7, 1, 'h001, 1'b0, 1'b1, 1);

        words = '{
            '{100, 150, 200, 250, 0, 0, 0, 0, 0, 0, 0, 0},
            '{100, 150, 200, 250, 100, 150, 200, 250, 100, 150, 0, 0},
            '{100, 150, 200, 250, 200, 150, 100, 150, 200, 250, 200, 150},
            '{'hFFFF0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
            '{100, 150, 200, 250, 0, 0, 0, 0, 0, 0, 0, 0},
            '{100, 150, 200, 0, 0, 0, 0, 0, 0, 0, 0, 0},
            '{100, 150, 200, 250, 200, 0, 0, 0, 0, 0, 0, 0},
            '{500, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}
        };

        // Reset values
        tag = "reset";
        push('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        push('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        push('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        run_vec(0);

        // Abort together with a valid start from IDLE: abort wins, f_ctrl goes to 0
        tag = "abort_start";
        set_cfg(vecs[0]);
        start = 1'b1;
        abort = 1'b1;
        cur_f = '0;
        push(cur_f, cur_p, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        start = 1'b0;
        abort = 1'b0;
        push(cur_f, cur_p, 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        for (int i = 1; i < int'(NV); i++) run_vec(i);

        // Reset during a triangle sweep, on the way down, then a clean restart
        tag = "reset_mid";
        set_cfg(vecs[2]);
        start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            push(FW'(words[2][k]), vecs[2].phase, 1'b1, 1'b1, 1'b0, 1'b0);
            step();
            start = 1'b0;
        end
        rst_n = 1'b0;
        push('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        push('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        cur_f = '0;
        cur_p = '0;
        run_vec(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep sequencer for the DDS core. It drives that core's frequency control word `f_ctrl` and phase offset `p_ctrl`, stepping the tuning word from a start value to a stop value. Each frequency is held for a programmable dwell time. Single, sawtooth-repeat and triangle sweeps are supported. The block sits between the register/config interface and the DDS instance, and its outputs connect directly to the DDS inputs.

## Interface

**Parameters**
- `F_WORD_N`, default 32: DDS total phase-accumulator width; must match the DDS instance.
- `P_WORD_M`, default 12: DDS phase/ROM address width; must match the DDS instance.
- `DWELL_W`, default 16: dwell counter width.
- `FW` (local, derived): `F_WORD_N-P_WORD_M`, the width of `f_ctrl`.

**Ports**
- `clk` in 1: single clock for the whole block.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: start request, sampled each cycle.
- `abort` in 1: stop the sweep immediately.
- `cfg_f_start` in FW: first tuning word.
- `cfg_f_stop` in FW: upper bound of the sweep, inclusive.
- `cfg_f_step` in FW: tuning-word increment.
- `cfg_dwell` in DWELL_W: cycles each word is held; 0 is treated as 1.
- `cfg_phase` in P_WORD_M: phase offset applied for the whole sweep.
- `cfg_mode` in 2: 0 = single, 1 = repeat (sawtooth), 2 = triangle, 3 = single.
- `f_ctrl` out FW: to DDS `f_ctrl`, registered.
- `p_ctrl` out P_WORD_M: to DDS `p_ctrl`, registered.
- `busy` out 1: sweep in progress.
- `step_pulse` out 1: one-cycle pulse on every load of a new `f_ctrl` value, including the first.
- `done` out 1: one-cycle pulse when a single sweep completes.
- `cfg_err` out 1: one-cycle pulse when `start` is rejected.

## Operation

**States:** IDLE and SWEEP, plus a direction flag `dir` (0 = up, 1 = down).

**Reset** (rst_n low at a clock edge):
- IDLE; `f_ctrl`=0, `p_ctrl`=0, `dir`=0, dwell counter 0.
- `busy`, `step_pulse`, `done`, `cfg_err` all 0.

**IDLE**
- `f_ctrl`/`p_ctrl` hold their last values.
- When `start`=1 and `abort`=0, all cfg inputs are checked:
  - If `cfg_f_step`==0 or `cfg_f_start`>`cfg_f_stop`: pulse `cfg_err`, remain IDLE.
  - Otherwise: latch all cfg inputs internally, set `f_ctrl`=`cfg_f_start`, `p_ctrl`=`cfg_phase`, `dir`=0, dwell counter 0. Enter SWEEP; `busy`=1, `step_pulse`=1.
- Cfg inputs are ignored at all other times; changes during SWEEP have no effect.

**SWEEP**
- Dwell counter increments each cycle.
- When it reaches D-1, where D = max(latched dwell, 1), the counter clears and the next word is computed in FW+1 bits:
  - Up (`dir`=0), `nxt = f + step`:
    - If `nxt` ≤ stop (carry counts as greater than stop): load `nxt`.
    - Else, mode single: go to IDLE, pulse `done`, `busy`=0, `f_ctrl` holds its last value.
    - Else, mode repeat: load the latched start value.
    - Else, mode triangle: set `dir`=1. Load `f - step` if it is ≥ start with no borrow; otherwise reload `f` unchanged.
  - Down (`dir`=1), `nxt = f - step`:
    - If no borrow and `nxt` ≥ start: load `nxt`.
    - Otherwise set `dir`=0. Load `f + step` if it is ≤ stop; otherwise reload `f`.
- `step_pulse`=1 in the cycle each load becomes visible, including a reload of an unchanged value.

**Abort and start priority**
- `abort`=1 in any state: the next cycle is IDLE with `f_ctrl`=0 (DDS frozen), `p_ctrl` held, `busy`=0, dwell counter 0. No `done` pulse.
- `abort` beats a simultaneous `start`.
- `start` during SWEEP is ignored.
- `rst_n` beats everything, including mid-sweep.

## Timing

- `start` sampled at edge T: `f_ctrl`=start, `busy`=1 and `step_pulse`=1 are visible after edge T.
- Every word is held exactly D cycles; the next word appears after edge T+k·D.
- Single sweep with N words: `done`=1 and `busy`=0 after edge T+N·D; `done` lasts 1 cycle.
- `cfg_err` appears after edge T and lasts 1 cycle.
- `abort` sampled at edge A: IDLE outputs are visible after edge A.
- The DDS adds its own register and ROM latency downstream; this block does not compensate for it.

## Test plan

- **Single sweep:** start=100, step=50, stop=260, dwell=3, mode 0. Expect `f_ctrl` 100,150,200,250, each held 3 cycles. `step_pulse` fires 4 times; `done` fires 12 cycles after `f_ctrl`=100 first appears; `f_ctrl` then holds 250 with `busy`=0.
- **Repeat and triangle:** same cfg with dwell=1.
  - Mode 1 gives 100,150,200,250,100,150,…
  - Mode 2 gives 100,150,200,250,200,150,100,150,…
  - `done` never fires in either mode.
- **Carry boundary:** start=0xFFFF0, step=0x20, stop=0xFFFFF (FW=20), mode 0. Expect `f_ctrl`=0xFFFF0 for D cycles, then `done`; no wrap to a small value.
- **Config error:** step=0, or start=300 with stop=200. Expect a 1-cycle `cfg_err` pulse; `busy` stays 0 and `f_ctrl` is unchanged. Dwell=0 runs identically to dwell=1.
- **Abort and start priority:**
  - `abort` mid-dwell gives `f_ctrl`=0 and `busy`=0 on the next cycle, with no `done`.
  - `abort`+`start` in the same cycle from IDLE: the block stays IDLE.
  - `start` pulsed during SWEEP has no effect on the sequence.
- **Reset mid-sweep:** `rst_n`=0 for one edge during mode 2. All outputs return to their reset values; a following `start` restarts the sweep from `cfg_f_start` with `dir` up.
